// File: rtl/bitbrick_if.sv
// Operand/result bundle for one bitbrick cell.
// Only clk and rst sit outside it.
interface bitbrick_if;
    logic       en;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] sel;
    logic [1:0] sh;
    logic [3:0] p;
    logic [3:0] p_q;
    logic [7:0] p_sh_q;
    logic       valid_q;

    modport master (
        output en, a, b, sel, sh,
        input  p, p_q, p_sh_q, valid_q
    );

    modport slave (
        input  en, a, b, sel, sh,
        output p, p_q, p_sh_q, valid_q
    );
endinterface

// File: rtl/bitbrick.sv
// 2x2 multiplier cell with per-operand signedness.
// Provides a combinational product and a registered, 2*sh-shifted copy for fusion trees.
module bitbrick (
    input logic       clk,
    input logic       rst,
    bitbrick_if.slave bus
);
    logic              a_sgn;
    logic              b_sgn;
    logic signed [5:0] a_ext;
    logic signed [5:0] b_ext;
    logic signed [5:0] prod;
    logic              res_sgn;
    logic [7:0]        p_ext;
    logic [7:0]        p_sh;

    // sel: 00 s*s, 01 u*u, 10 s*u, 11 u*s
    assign a_sgn   = ~bus.sel[0];
    assign b_sgn   = ~(bus.sel[1] ^ bus.sel[0]);
    assign a_ext   = {{4{a_sgn & bus.a[1]}}, bus.a};
    assign b_ext   = {{4{b_sgn & bus.b[1]}}, bus.b};
    assign prod    = a_ext * b_ext;
    assign bus.p   = prod[3:0];

    assign res_sgn = (bus.sel != 2'b01);
    assign p_ext   = {{4{res_sgn & bus.p[3]}}, bus.p};
    assign p_sh    = p_ext << {bus.sh, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.p_q     <= 4'd0;
            bus.p_sh_q  <= 8'd0;
            bus.valid_q <= 1'b0;
        end else begin
            bus.valid_q <= bus.en;
            if (bus.en) begin
                bus.p_q    <= bus.p;
                bus.p_sh_q <= p_sh;
            end
        end
    end
endmodule

// File: tb/tb_bitbrick.sv
// Self-checking bench for bitbrick: exhaustive combinational sweep, fusion example,
// directed registered-path cases and a randomized run against an arithmetic model.
module tb_bitbrick;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    bitbrick_if bb ();

    bitbrick u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Ideal integer product given signedness rules.
    function automatic int ideal(input logic [1:0] a, input logic [1:0] b, input logic [1:0] sel);
        int av, bv;
        bit as, bs;
        case (sel)
            2'b00:   begin as = 1; bs = 1; end
            2'b01:   begin as = 0; bs = 0; end
            2'b10:   begin as = 1; bs = 0; end
            default: begin as = 0; bs = 1; end
        endcase
        av = (as && a >= 2) ? int'(a) - 4 : int'(a);
        bv = (bs && b >= 2) ? int'(b) - 4 : int'(b);
        return av * bv;
    endfunction

    function automatic logic [31:0] exp_p(input logic [1:0] a, input logic [1:0] b,
                                          input logic [1:0] sel);
        return 32'(ideal(a, b, sel) & 15);
    endfunction

    function automatic logic [31:0] exp_sh(input logic [1:0] a, input logic [1:0] b,
                                           input logic [1:0] sel, input logic [1:0] sh);
        return 32'((ideal(a, b, sel) * (1 << (2 * int'(sh)))) & 255);
    endfunction

    task automatic drive(input logic e, input logic [1:0] a, input logic [1:0] b,
                         input logic [1:0] sel, input logic [1:0] sh);
        bb.en = e; bb.a = a; bb.b = b; bb.sel = sel; bb.sh = sh;
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  pv [4];
    logic [7:0]  fsum;
    logic [3:0]  m_pq;
    logic [7:0]  m_psh;
    logic        m_v;
    logic [3:0]  hold_pq;
    logic [7:0]  hold_psh;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drive(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
        #12;
        check("reset_p_q", 32'(bb.p_q), 32'd0);
        check("reset_p_sh_q", 32'(bb.p_sh_q), 32'd0);
        check("reset_valid_q", 32'(bb.valid_q), 32'd0);

        // Exhaustive combinational sweep (works regardless of rst).
        for (int s = 0; s < 4; s++)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    drive(1'b0, 2'(i), 2'(j), 2'(s), 2'd0);
                    #1;
                    check($sformatf("p_a%0d_b%0d_sel%0d", i, j, s), 32'(bb.p),
                          exp_p(2'(i), 2'(j), 2'(s)));
                end
        drive(1'b0, 2'b11, 2'b11, 2'b01, 2'd0);
        #1;
        check("p_unsigned_max", 32'(bb.p), 32'd9);

        // 4x4 fusion: A=1011, B=0110.
        drive(1'b0, 2'b11, 2'b10, 2'b01, 2'd0); #1; pv[0] = bb.p;
        drive(1'b0, 2'b10, 2'b10, 2'b10, 2'd0); #1; pv[1] = bb.p;
        drive(1'b0, 2'b01, 2'b11, 2'b10, 2'd0); #1; pv[2] = bb.p;
        drive(1'b0, 2'b01, 2'b10, 2'b00, 2'd0); #1; pv[3] = bb.p;
        check("fuse_p0", 32'(pv[0]), 32'h6);
        check("fuse_p1", 32'(pv[1]), 32'hC);
        check("fuse_p2", 32'(pv[2]), 32'h3);
        check("fuse_p3", 32'(pv[3]), 32'hE);
        fsum = ({{4{pv[3][3]}}, pv[3]} << 4) + ({{4{pv[1][3]}}, pv[1]} << 2)
             + ({{4{pv[2][3]}}, pv[2]} << 2) + {4'd0, pv[0]};
        check("fuse_sum", 32'(fsum), 32'hE2);

        // Release reset away from the edge.
        @(negedge clk);
        rst = 1'b0;

        drive(1'b1, 2'b10, 2'b01, 2'b00, 2'b10);
        edge_step();
        check("reg_p_q", 32'(bb.p_q), 32'hE);
        check("reg_p_sh_q", 32'(bb.p_sh_q), 32'hE0);
        check("reg_valid_q", 32'(bb.valid_q), 32'd1);

        hold_pq  = 4'hE;
        hold_psh = 8'hE0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 2'($urandom));
            edge_step();
            check($sformatf("hold_p_q_%0d", k), 32'(bb.p_q), 32'(hold_pq));
            check($sformatf("hold_p_sh_q_%0d", k), 32'(bb.p_sh_q), 32'(hold_psh));
            check($sformatf("hold_valid_%0d", k), 32'(bb.valid_q), 32'd0);
        end

        drive(1'b1, 2'b11, 2'b11, 2'b01, 2'b01);
        edge_step();
        check("ushift_p_sh_q", 32'(bb.p_sh_q), 32'h24);
        check("ushift_p_q", 32'(bb.p_q), 32'h9);

        // Async reset mid-cycle after a capture.
        #3;
        rst = 1'b1;
        #1;
        check("arst_p_q", 32'(bb.p_q), 32'd0);
        check("arst_p_sh_q", 32'(bb.p_sh_q), 32'd0);
        check("arst_valid", 32'(bb.valid_q), 32'd0);
        drive(1'b1, 2'b01, 2'b01, 2'b00, 2'b00);
        edge_step();
        check("arst_nocap_p_q", 32'(bb.p_q), 32'd0);
        check("arst_nocap_valid", 32'(bb.valid_q), 32'd0);
        rst = 1'b0;
        edge_step();
        check("post_rst_p_q", 32'(bb.p_q), 32'h1);
        check("post_rst_valid", 32'(bb.valid_q), 32'd1);

        // Randomized run against the arithmetic model.
        m_pq  = bb.p_q;
        m_psh = bb.p_sh_q;
        m_v   = bb.valid_q;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
                  2'($urandom), 2'($urandom));
            #1;
            check("rnd_p", 32'(bb.p), exp_p(bb.a, bb.b, bb.sel));
            if ($urandom_range(0, 19) == 0) begin
                #1;
                rst = 1'b1;
                #1;
                m_pq = 4'd0; m_psh = 8'd0; m_v = 1'b0;
                check("rnd_arst_p_sh_q", 32'(bb.p_sh_q), 32'd0);
                rst = 1'b0;
            end
            if (bb.en) begin
                m_pq  = 4'(exp_p(bb.a, bb.b, bb.sel));
                m_psh = 8'(exp_sh(bb.a, bb.b, bb.sel, bb.sh));
                m_v   = 1'b1;
            end else begin
                m_v = 1'b0;
            end
            edge_step();
            check("rnd_p_q", 32'(bb.p_q), 32'(m_pq));
            check("rnd_p_sh_q", 32'(bb.p_sh_q), 32'(m_psh));
            check("rnd_valid_q", 32'(bb.valid_q), 32'(m_v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
